ibex_ex_wb_buffer: RTL
======================

// Module: ibex_ex_wb_buffer
// PURPOSE
//  Writeback-side consumer of the execution stage's result/valid interface.
//  Captures each completed EX result (ALU, MUL/DIV or FPU) with its destination tag into a small in-order FIFO.
//  Drains the FIFO into the integer or FP register-file write port whenever that port is granted.
//  Exposes the newest pending entry for operand forwarding. Decouples EX completion from register-file port arbitration.
// PARAMETERS
//  DataWidth  32  width of result / register-file write data
//  RegAddrW   5   register address width
//  Depth      2   FIFO entries; power of two, >= 2
// PORTS
//  clk_i           in   1          clock
//  rst_i           in   1          reset, asynchronous, active-high
//  ex_valid_i      in   1          EX result valid this cycle
//  ex_ready_o      out  1          buffer can accept a result
//  ex_result_i     in   DataWidth  EX result data
//  ex_rd_addr_i    in   RegAddrW   destination register
//  ex_rd_fp_i      in   1          1: FP register file, 0: integer
//  ex_rd_we_i      in   1          instruction writes a register
//  flush_i         in   1          discard all pending and incoming results
//  wb_ready_i      in   1          register-file write port granted this cycle
//  rf_int_we_o     out  1          integer RF write enable
//  rf_fp_we_o      out  1          FP RF write enable
//  rf_waddr_o      out  RegAddrW   RF write address (shared)
//  rf_wdata_o      out  DataWidth  RF write data (shared)
//  fwd_valid_o     out  1          newest pending entry is valid
//  fwd_fp_o        out  1          newest entry targets FP RF
//  fwd_addr_o      out  RegAddrW   newest entry address
//  fwd_data_o      out  DataWidth  newest entry data
//  count_o         out  $clog2(Depth+1)  occupied entries
// BEHAVIOUR
//  - Reset (async, rst_i=1): count=0, rd/wr pointers=0, entry storage=0.
//    All outputs are 0 during reset except ex_ready_o=1.
//  - ex_ready_o = (count < Depth); registered-state only, no dependency on wb_ready_i or ex_valid_i.
//  - Push: ex_valid_i & ex_ready_o & ex_rd_we_i & ~flush_i. Stores {fp, addr, data} at wr_ptr; wr_ptr increments modulo Depth.
//  - Accept-and-drop: ex_valid_i & ex_ready_o & ~ex_rd_we_i is handshaken, nothing stored.
//  - Integer x0: a push with ex_rd_fp_i=0 and ex_rd_addr_i=0 is stored.
//    On pop it asserts no write enable but is still popped; ordering is preserved. FP f0 is a real register.
//  - Pop: (count>0) & wb_ready_i. Head entry drives the RF outputs combinationally in that cycle.
//    rd_ptr increments modulo Depth at the edge.
//  - RF outputs: rf_int_we_o = pop & ~head.fp & (head.addr!=0); rf_fp_we_o = pop & head.fp.
//    rf_waddr_o/rf_wdata_o = head fields when either we is high, else 0.
//  - Latency: a result pushed at edge N is writable at the earliest in cycle N+1 (no empty bypass).
//  - Simultaneous push & pop: count unchanged, both pointers advance.
//    When full, no push is possible; the pop frees a slot visible next cycle.
//  - Forwarding: fwd_* = entry at (wr_ptr-1) mod Depth when count>0, else all 0.
//    The newest entry wins over older entries with the same address.
//  - flush_i: at the next edge count=0, wr_ptr=rd_ptr=0; any same-cycle push is discarded.
//    RF writes still occur in the flush cycle if a pop is active (already-committed results).
//  - Reset mid-operation discards all entries immediately (async); no RF write is asserted while rst_i=1.
//  - Assertions: count never exceeds Depth; no push when ~ex_ready_o; rf_int_we_o & rf_fp_we_o never both 1.
// TESTING
//  - Reset: rst_i=1 mid-traffic with 2 entries pending -> count_o=0, rf_*_we_o=0, ex_ready_o=1 in the same cycle.
//  - Single push int x5=0xDEADBEEF, wb_ready_i=1 -> next cycle rf_int_we_o=1, addr=5, data=0xDEADBEEF; count 1->0.
//  - Backpressure: wb_ready_i=0, push x1=1, f2=2, attempt x3=3 -> ex_ready_o=0 at count=2, x3 not taken.
//    Release wb_ready_i -> writes x1 then f2 (rf_fp_we_o) in order.
//  - x0 drop: push x0=0x55 then x7=0x77 with wb_ready_i=1 -> first pop has no we; x7 written the following cycle.
//  - Simultaneous push/pop at count=1 for 8 cycles with incrementing data -> count stays 1, writes in order.
//    fwd_data_o always equals the last pushed value.
//  - Flush with count=2 plus concurrent push -> next cycle count=0, fwd_valid_o=0; no write of flushed entries ever.

Source files
------------

// File: rtl/ibex_ex_wb_buffer_if.sv
// EX-result / register-file-writeback bundle between the execution stage and the
// writeback buffer. The EX side plus writeback grant is the master; the buffer is the slave.
interface ibex_ex_wb_buffer_if #(
    parameter int DataWidth = 32,
    parameter int RegAddrW  = 5,
    parameter int Depth     = 2
);
    localparam int CntW = $clog2(Depth + 1);

    logic                 ex_valid_i;
    logic                 ex_ready_o;
    logic [DataWidth-1:0] ex_result_i;
    logic [RegAddrW-1:0]  ex_rd_addr_i;
    logic                 ex_rd_fp_i;
    logic                 ex_rd_we_i;
    logic                 flush_i;
    logic                 wb_ready_i;
    logic                 rf_int_we_o;
    logic                 rf_fp_we_o;
    logic [RegAddrW-1:0]  rf_waddr_o;
    logic [DataWidth-1:0] rf_wdata_o;
    logic                 fwd_valid_o;
    logic                 fwd_fp_o;
    logic [RegAddrW-1:0]  fwd_addr_o;
    logic [DataWidth-1:0] fwd_data_o;
    logic [CntW-1:0]      count_o;

    modport master (
        output ex_valid_i, ex_result_i, ex_rd_addr_i, ex_rd_fp_i, ex_rd_we_i,
               flush_i, wb_ready_i,
        input  ex_ready_o, rf_int_we_o, rf_fp_we_o, rf_waddr_o, rf_wdata_o,
               fwd_valid_o, fwd_fp_o, fwd_addr_o, fwd_data_o, count_o
    );

    modport slave (
        input  ex_valid_i, ex_result_i, ex_rd_addr_i, ex_rd_fp_i, ex_rd_we_i,
               flush_i, wb_ready_i,
        output ex_ready_o, rf_int_we_o, rf_fp_we_o, rf_waddr_o, rf_wdata_o,
               fwd_valid_o, fwd_fp_o, fwd_addr_o, fwd_data_o, count_o
    );
endinterface

// File: rtl/ibex_ex_wb_buffer.sv
// In-order FIFO between EX completion and the integer/FP register-file write port,
// with forwarding of the newest pending result.
module ibex_ex_wb_buffer #(
    parameter int DataWidth = 32,
    parameter int RegAddrW  = 5,
    parameter int Depth     = 2
) (
    input logic               clk_i,
    input logic               rst_i,
    ibex_ex_wb_buffer_if.slave bus
);
    localparam int CntW = $clog2(Depth + 1);
    localparam int PtrW = $clog2(Depth);
    localparam logic [CntW-1:0] DepthC = CntW'(Depth);

    typedef struct packed {
        logic                 fp;
        logic [RegAddrW-1:0]  addr;
        logic [DataWidth-1:0] data;
    } entry_t;

    entry_t          mem_q [Depth];
    entry_t          mem_d [Depth];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;

    logic   ex_ready, push, pop;
    entry_t head, newest;

    always_comb begin
        // NOTE: every comb-assigned signal gets a default first, otherwise a latch is inferred.
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        ex_ready = (count_q < DepthC);
        push     = bus.ex_valid_i & ex_ready & bus.ex_rd_we_i & ~bus.flush_i;
        pop      = (count_q != '0) & bus.wb_ready_i;

        if (bus.flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = '{fp: bus.ex_rd_fp_i, addr: bus.ex_rd_addr_i, data: bus.ex_result_i};
                wr_ptr_d        = wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CntW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CntW'(1);
            end
        end
    end

    always_comb begin
        head   = mem_q[rd_ptr_q];
        newest = mem_q[wr_ptr_q - PtrW'(1)];

        bus.ex_ready_o  = ex_ready;
        bus.count_o     = count_q;
        // Integer x0 entries still pop to keep ordering, but never write.
        bus.rf_int_we_o = pop & ~head.fp & (head.addr != '0);
        bus.rf_fp_we_o  = pop & head.fp;
        bus.rf_waddr_o  = (bus.rf_int_we_o | bus.rf_fp_we_o) ? head.addr : '0;
        bus.rf_wdata_o  = (bus.rf_int_we_o | bus.rf_fp_we_o) ? head.data : '0;

        bus.fwd_valid_o = (count_q != '0);
        bus.fwd_fp_o    = bus.fwd_valid_o ? newest.fp   : 1'b0;
        bus.fwd_addr_o  = bus.fwd_valid_o ? newest.addr : '0;
        bus.fwd_data_o  = bus.fwd_valid_o ? newest.data : '0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            // NOTE: storage is reset here too so forwarded/written data never exposes X after reset.
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

    assert property (@(posedge clk_i) disable iff (rst_i) count_q <= DepthC);
    assert property (@(posedge clk_i) disable iff (rst_i) push |-> ex_ready);
    assert property (@(posedge clk_i) disable iff (rst_i) !(bus.rf_int_we_o && bus.rf_fp_we_o));

endmodule
